// File: rtl/tmr_sched_pkg.sv
`default_nettype none
// =====================================================================
// tmr_sched_pkg : shared types and timer mode constants for tmr_oneshot_sched
// Revision      : 1.0
// =====================================================================
package tmr_sched_pkg;

    localparam int CW_DEFAULT = 32;

    // Static timer mode: one-shot, down-count, timer clock, no capture, no PWM
    localparam logic C_TMR_MODE  = 1'b0;
    localparam logic C_TMR_UD    = 1'b0;
    localparam logic C_TMR_TC    = 1'b1;
    localparam logic C_TMR_CP    = 1'b0;
    localparam logic C_TMR_PWMEN = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_RUN   = 3'd2,
`ifdef TMR_SCHED_ABORT_EN
        ST_FIN   = 3'd3,
        ST_ABORT = 3'd4
`else
        ST_FIN   = 3'd3
`endif
    } state_t;

endpackage
`default_nettype wire

// File: rtl/tmr_sched_rr_arb.sv
`default_nettype none
// =====================================================================
// tmr_sched_rr_arb : combinational round-robin picker, first request at or after ptr
// Revision         : 1.0
// =====================================================================
module tmr_sched_rr_arb
    import tmr_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [NREQ-1:0] onehot_o,
    output logic [IW-1:0]   idx_o
);

    logic [IW-1:0] cand;

    // Scan from the farthest offset down so the nearest request wins last
    always_comb begin
        idx_o    = '0;
        onehot_o = '0;
        cand     = '0;
        for (int off = NREQ - 1; off >= 0; off--) begin
            cand = IW'((int'(ptr_i) + off) % NREQ);
            if (req_i[cand]) begin
                idx_o = cand;
            end
        end
        if (|req_i) begin
            onehot_o[idx_o] = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/tmr_oneshot_sched.sv
`default_nettype none
// =====================================================================
// tmr_oneshot_sched : shares one one-shot down timer among NREQ timeout users.
// Optional macro    : TMR_SCHED_ABORT_EN (req drop during RUN cancels the timeout)
// Revision          : 1.0
// =====================================================================
module tmr_oneshot_sched
    import tmr_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int CW   = CW_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_i,
    input  logic [NREQ*CW-1:0] delay_i,
    input  logic [15:0]       pre_i,
    output logic [NREQ-1:0]   grant_o,
    output logic [NREQ-1:0]   done_o,
    output logic              busy_o,
    output logic              tmr_en_o,
    output logic [CW-1:0]     tmr_load_o,
    output logic [15:0]       tmr_pre_o,
    output logic              tmr_ovf_clr_o,
    output logic              tmr_mode_o,
    output logic              tmr_ud_o,
    output logic              tmr_tc_o,
    output logic              tmr_cp_o,
    output logic              tmr_pwmen_o,
    input  logic              tmr_ovf_i
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]   load_q, load_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [NREQ-1:0] done_q, done_d;
    logic [NREQ-1:0] pick_oh;
    logic [IW-1:0]   pick_idx;
    logic [IW-1:0]   idx_next;

    tmr_sched_rr_arb #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_arb (
        .req_i    (req_i),
        .ptr_i    (ptr_q),
        .onehot_o (pick_oh),
        .idx_o    (pick_idx)
    );

    assign idx_next = (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            ptr_q   <= '0;
            load_q  <= '0;
            grant_q <= '0;
            done_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            load_q  <= load_d;
            grant_q <= grant_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        load_d  = load_q;
        grant_d = grant_q;
        done_d  = '0;
        case (state_q)
            ST_IDLE: begin
                grant_d = '0;
                if (|req_i) begin
                    idx_d   = pick_idx;
                    grant_d = pick_oh;
                    state_d = ST_SETUP;
                    for (int i = 0; i < NREQ; i++) begin
                        if (IW'(i) == pick_idx) begin
                            load_d = delay_i[i*CW +: CW];
                        end
                    end
                end
            end
            // Timer is disabled here so it takes LOAD into its counter
            ST_SETUP: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (tmr_ovf_i) begin
                    done_d  = grant_q;
                    state_d = ST_FIN;
                end
`ifdef TMR_SCHED_ABORT_EN
                else if (!req_i[idx_q]) begin
                    state_d = ST_ABORT;
                end
`endif
            end
            ST_FIN: begin
                ptr_d   = idx_next;
                grant_d = '0;
                state_d = ST_IDLE;
            end
`ifdef TMR_SCHED_ABORT_EN
            ST_ABORT: begin
                ptr_d   = idx_next;
                grant_d = '0;
                state_d = ST_IDLE;
            end
`endif
            default: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    assign grant_o    = grant_q;
    assign done_o     = done_q;
    assign busy_o     = (state_q != ST_IDLE);
    assign tmr_en_o   = (state_q == ST_RUN);
    assign tmr_load_o = load_q;
    assign tmr_pre_o  = pre_i;
`ifdef TMR_SCHED_ABORT_EN
    assign tmr_ovf_clr_o = (state_q == ST_FIN) || (state_q == ST_ABORT);
`else
    assign tmr_ovf_clr_o = (state_q == ST_FIN);
`endif

    assign tmr_mode_o  = C_TMR_MODE;
    assign tmr_ud_o    = C_TMR_UD;
    assign tmr_tc_o    = C_TMR_TC;
    assign tmr_cp_o    = C_TMR_CP;
    assign tmr_pwmen_o = C_TMR_PWMEN;

endmodule
`default_nettype wire

// File: tb/tb_tmr_oneshot_sched.sv
`default_nettype none
// =====================================================================
// tb_tmr_oneshot_sched : directed bench with a one-shot timer model and scoreboard
// Revision             : 1.0
// =====================================================================
module tb_tmr_oneshot_sched;

    localparam int NREQ = 4;
    localparam int CW   = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req;
    logic [NREQ*CW-1:0] delay;
    logic [15:0]       pre;
    logic [NREQ-1:0]   grant, done;
    logic              busy, tmr_en, tmr_ovf_clr, tmr_ovf;
    logic [CW-1:0]     tmr_load;
    logic [15:0]       tmr_pre;
    logic              tmr_mode, tmr_ud, tmr_tc, tmr_cp, tmr_pwmen;

    tmr_oneshot_sched #(.NREQ(NREQ), .CW(CW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_i         (req),
        .delay_i       (delay),
        .pre_i         (pre),
        .grant_o       (grant),
        .done_o        (done),
        .busy_o        (busy),
        .tmr_en_o      (tmr_en),
        .tmr_load_o    (tmr_load),
        .tmr_pre_o     (tmr_pre),
        .tmr_ovf_clr_o (tmr_ovf_clr),
        .tmr_mode_o    (tmr_mode),
        .tmr_ud_o      (tmr_ud),
        .tmr_tc_o      (tmr_tc),
        .tmr_cp_o      (tmr_cp),
        .tmr_pwmen_o   (tmr_pwmen),
        .tmr_ovf_i     (tmr_ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // One-shot down-counter: loads while disabled, ticks every PRE+1 clocks, sticky OVF at zero
    logic [CW-1:0] t_cnt;
    logic [15:0]   t_pcnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_cnt   <= '0;
            t_pcnt  <= '0;
            tmr_ovf <= 1'b0;
        end else begin
            if (tmr_ovf_clr)                  tmr_ovf <= 1'b0;
            else if (tmr_en && t_cnt == '0)   tmr_ovf <= 1'b1;
            if (!tmr_en) begin
                t_cnt  <= tmr_load;
                t_pcnt <= '0;
            end else if (t_cnt != '0) begin
                if (t_pcnt == tmr_pre) begin
                    t_pcnt <= '0;
                    t_cnt  <= t_cnt - 1'b1;
                end else begin
                    t_pcnt <= t_pcnt + 1'b1;
                end
            end
        end
    end

    typedef struct {
        int idx;
        int d;
        int lo;
        int hi;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   m_ptr    = 0;
    int   g_cyc    = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int rr_model(input logic [NREQ-1:0] r, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic set_delay(input int i, input int v);
        delay[i*CW +: CW] = v;
    endtask

    // Record the expected winner of the next arbitration and its expiry window
    task automatic push_exp(input int p);
        exp_t e;
        e.idx = rr_model(req, m_ptr);
        e.d   = delay[e.idx*CW +: CW];
        e.lo  = e.d * (p + 1);
        e.hi  = e.lo + 4;
        sb.push_back(e);
    endtask

    task automatic wait_grant(output int lat);
        exp_t e;
        lat = 0;
        e = sb[sb.size()-1];
        for (int k = 0; k < 8; k++) begin
            tick();
            lat++;
            if (grant != '0) break;
        end
        g_cyc = cyc;
        chk($sformatf("grant_req%0d", e.idx), grant, 64'(1 << e.idx));
        chk($sformatf("load_req%0d", e.idx), tmr_load, 64'(e.d));
    endtask

    task automatic wait_done(input int budget);
        exp_t e;
        int   el;
        for (int k = 0; k < budget; k++) begin
            tick();
            if (done != '0) break;
        end
        if (sb.size() == 0) begin
            chk("sb_empty", done, 0);
        end else begin
            e  = sb.pop_front();
            el = cyc - g_cyc;
            chk($sformatf("done_req%0d", e.idx), done, 64'(1 << e.idx));
            chk($sformatf("done_window_el%0d", el), 64'(el >= e.lo && el <= e.hi), 1);
            req[e.idx] = 1'b0;
            m_ptr = (e.idx + 1) % NREQ;
            tick();
            chk("done_single", done, 0);
            chk("idle_busy", busy, 0);
            chk("ovf_cleared", tmr_ovf, 0);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        m_ptr = 0;
        sb.delete();
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int order[$];
        logic [NREQ-1:0] seen;
        logic done_seen;

        rst_n = 1'b0;
        req   = '0;
        delay = '0;
        pre   = '0;
        do_reset();

        chk("rst_grant", grant, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_en", tmr_en, 0);
        chk("rst_load", tmr_load, 0);
        chk("rst_ovf_clr", tmr_ovf_clr, 0);
        chk("const_modes", {tmr_mode, tmr_ud, tmr_tc, tmr_cp, tmr_pwmen}, 5'b00100);

        // Single request, delay 10
        set_delay(0, 10);
        req[0] = 1'b1;
        push_exp(0);
        wait_grant(lat);
        chk("grant_latency", lat, 1);
        chk("setup_busy", busy, 1);
        chk("setup_en", tmr_en, 0);
        tick();
        chk("run_en", tmr_en, 1);
        wait_done(40);

        // Round-robin with all requesters held and re-asserted
        do_reset();
        for (int i = 0; i < NREQ; i++) set_delay(i, i + 2);
        req  = '1;
        seen = '0;
        for (int k = 0; k < 5; k++) begin
            push_exp(0);
            order.push_back(sb[sb.size()-1].idx);
            wait_grant(lat);
            if (k < 4) seen = seen | grant;
            wait_done(40);
            if (k < 4) req[order[k]] = 1'b1;
            else       req = '0;
        end
        chk("rr_all_served", seen, 4'hF);
        chk("rr_order", {order[0][3:0], order[1][3:0], order[2][3:0], order[3][3:0], order[4][3:0]}, 20'h01230);

        // Prescaler: delay 5, pre 3
        set_delay(1, 5);
        pre    = 16'd3;
        req[1] = 1'b1;
        push_exp(3);
        wait_grant(lat);
        chk("pre_pass_grant", tmr_pre, 3);
        wait_done(60);
        chk("pre_pass_end", tmr_pre, 3);
        pre = '0;

        // Zero delay
        set_delay(2, 0);
        req[2] = 1'b1;
        push_exp(0);
        wait_grant(lat);
        wait_done(10);

        // Overflow and request drop in the same RUN cycle
        set_delay(3, 4);
        req[3] = 1'b1;
        push_exp(0);
        wait_grant(lat);
        for (int k = 0; k < 30; k++) begin
            if (tmr_ovf) break;
            tick();
        end
        chk("simul_ovf_seen", tmr_ovf, 1);
        req[3] = 1'b0;
        wait_done(3);

        // Long timeout on req 2, other requester arrives while busy, then drop at 50
        set_delay(2, 1000);
        req[2] = 1'b1;
        push_exp(0);
        wait_grant(lat);
        set_delay(1, 3);
        req[1] = 1'b1;
        tick();
        chk("nonowner_ignored", grant, 4'b0100);
        repeat (49) tick();
        req[2] = 1'b0;
`ifdef TMR_SCHED_ABORT_EN
        tick();
        chk("abort_ovf_clr", tmr_ovf_clr, 1);
        chk("abort_no_done", done, 0);
        chk("abort_en", tmr_en, 0);
        void'(sb.pop_front());
        m_ptr = 3;
        push_exp(0);
        wait_grant(lat);
        chk("abort_regrant_le3", 64'(lat + 1 <= 3), 1);
        wait_done(20);
`else
        wait_done(1100);
        push_exp(0);
        wait_grant(lat);
        wait_done(20);
`endif

        // Reset in the middle of a run
        set_delay(0, 100);
        req[0] = 1'b1;
        push_exp(0);
        wait_grant(lat);
        repeat (10) tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_grant", grant, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_en", tmr_en, 0);
        chk("mid_rst_load", tmr_load, 0);
        chk("mid_rst_ovf_clr", tmr_ovf_clr, 0);
        req = '0;
        repeat (2) tick();
        rst_n = 1'b1;
        m_ptr = 0;
        sb.delete();
        done_seen = 1'b0;
        repeat (120) begin
            tick();
            done_seen = done_seen | (|done);
        end
        chk("mid_rst_no_done", done_seen, 0);

        // Fresh service after reset
        set_delay(3, 2);
        req[3] = 1'b1;
        push_exp(0);
        wait_grant(lat);
        wait_done(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
